// File: rtl/mod_vga_timing.sv
// 640x480@60 VGA raster generator: free-running pixel counters plus sync/blank
// signals delayed by PIX_LATENCY so they line up with the overlay's pixel result.
module mod_vga_timing #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned PIX_LATENCY = 1
) (
    input  logic       in_clk,
    input  logic       in_reset,
    input  logic       in_pixel,
    output logic [9:0] out_pix_x,
    output logic [9:0] out_pix_y,
    output logic       out_frame_start,
    output logic       out_active,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic       out_video
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] X_HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] X_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] Y_VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] Y_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_x;
    logic [9:0] r_y;

    logic w_act;
    logic w_hs_n;
    logic w_vs_n;

    logic [PIX_LATENCY-1:0] r_act_dly;
    logic [PIX_LATENCY-1:0] r_hs_n_dly;
    logic [PIX_LATENCY-1:0] r_vs_n_dly;

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= (r_y == Y_LAST) ? '0 : r_y + 10'd1;
        end else begin
            r_x <= r_x + 10'd1;
        end
    end

    always_comb begin
        w_act  = (r_x < X_ACT) && (r_y < Y_ACT);
        w_hs_n = !((r_x >= X_HS_BEG) && (r_x < X_HS_END));
        w_vs_n = !((r_y >= Y_VS_BEG) && (r_y < Y_VS_END));
    end

    // Every stage loads idle on reset so no stale sync pulse drains out afterwards.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_act_dly  <= '0;
            r_hs_n_dly <= '1;
            r_vs_n_dly <= '1;
        end else begin
            r_act_dly[0]  <= w_act;
            r_hs_n_dly[0] <= w_hs_n;
            r_vs_n_dly[0] <= w_vs_n;
            for (int i = 1; i < int'(PIX_LATENCY); i++) begin
                r_act_dly[i]  <= r_act_dly[i-1];
                r_hs_n_dly[i] <= r_hs_n_dly[i-1];
                r_vs_n_dly[i] <= r_vs_n_dly[i-1];
            end
        end
    end

    assign out_pix_x       = r_x;
    assign out_pix_y       = r_y;
    assign out_frame_start = (r_x == 10'd0) && (r_y == 10'd0);
    assign out_active      = r_act_dly[PIX_LATENCY-1];
    assign out_hsync       = r_hs_n_dly[PIX_LATENCY-1];
    assign out_vsync       = r_vs_n_dly[PIX_LATENCY-1];
    assign out_video       = in_pixel & r_act_dly[PIX_LATENCY-1];

endmodule

// File: tb/tb_mod_vga_timing.sv
// Bench for mod_vga_timing: instance A uses full 640x480 timing with latency 1,
// instance B a 10-line frame with latency 3 so whole frames fit in a short run.
module tb_mod_vga_timing;

    logic clk;
    logic a_reset, a_pixel;
    logic b_reset, b_pixel;
    logic [9:0] a_x, a_y, b_x, b_y;
    logic a_fs, a_act, a_hs, a_vs, a_vid;
    logic b_fs, b_act, b_hs, b_vs, b_vid;
    logic [3:0] b_hist;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        int    cyc;
        int    id;
        int    exp;
        string name;
    } snap_t;

    snap_t snap_q[$];
    int q_a_hfx[$], q_a_hgap[$], q_a_hlow[$], q_a_lvid[$];
    int q_b_vfall[$], q_b_vlow[$], q_b_vid[$], q_b_lvid[$], q_b_fsgap[$];

    mod_vga_timing u_a (
        .in_clk         (clk),
        .in_reset       (a_reset),
        .in_pixel       (a_pixel),
        .out_pix_x      (a_x),
        .out_pix_y      (a_y),
        .out_frame_start(a_fs),
        .out_active     (a_act),
        .out_hsync      (a_hs),
        .out_vsync      (a_vs),
        .out_video      (a_vid)
    );

    mod_vga_timing #(
        .V_ACTIVE   (4),
        .V_FP       (2),
        .V_SYNC     (2),
        .V_BP       (2),
        .PIX_LATENCY(3)
    ) u_b (
        .in_clk         (clk),
        .in_reset       (b_reset),
        .in_pixel       (b_pixel),
        .out_pix_x      (b_x),
        .out_pix_y      (b_y),
        .out_frame_start(b_fs),
        .out_active     (b_act),
        .out_hsync      (b_hs),
        .out_vsync      (b_vs),
        .out_video      (b_vid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_snap(input int c, input int id, input int e, input string n);
        snap_t s;
        int    i;
        s = '{cyc: c, id: id, exp: e, name: n};
        i = 0;
        while (i < snap_q.size() && snap_q[i].cyc <= c) i++;
        snap_q.insert(i, s);
    endtask

    function automatic int sig_val(input int id);
        case (id)
            0:  return int'(a_x);
            1:  return int'(a_y);
            2:  return int'(a_hs);
            3:  return int'(a_vs);
            4:  return int'(a_act);
            5:  return int'(a_vid);
            6:  return int'(a_fs);
            10: return int'(b_x);
            11: return int'(b_y);
            12: return int'(b_hs);
            13: return int'(b_vs);
            14: return int'(b_act);
            15: return int'(b_vid);
            16: return int'(b_fs);
            default: return -1;
        endcase
    endfunction

    // B's pixel is a 3-cycle-delayed copy of (x==5), as a latency-3 overlay would return.
    initial begin
        b_hist  = '0;
        b_pixel = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            b_hist  = {b_hist[2:0], (b_x == 10'd5)};
            b_pixel = b_hist[3];
        end
    end

    // Monitor state
    logic [9:0] pa_x = '0, pb_x = '0;
    logic pa_hs = 1'b1, pb_vs = 1'b1, pb_fs = 1'b1;
    int a_lvid = 0, a_hfall = -1, a_hlow = 0;
    int b_lvid = 0, b_vlow = -1, b_fs_last = -1;

    always @(negedge clk) begin
        snap_t s;
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            s = snap_q.pop_front();
            if (s.cyc == cyc) check(s.name, sig_val(s.id), s.exp);
            else check({s.name, "_missed"}, -1, s.exp);
        end
        if (cyc >= 3) begin
            if (a_x == 10'd0 && pa_x == 10'd799) begin
                if (q_a_lvid.size() > 0) check("a_line_video", a_lvid, q_a_lvid.pop_front());
                a_lvid = 0;
            end
            if (a_vid === 1'b1) a_lvid++;
            if (a_hs === 1'b0) begin
                if (pa_hs === 1'b1) begin
                    if (q_a_hfx.size() > 0) check("a_hfall_prev_x", int'(pa_x), q_a_hfx.pop_front());
                    if (a_hfall >= 0 && q_a_hgap.size() > 0)
                        check("a_hfall_gap", cyc - a_hfall, q_a_hgap.pop_front());
                    a_hfall = cyc;
                    a_hlow  = 0;
                end
                a_hlow++;
            end else if (pa_hs === 1'b0 && q_a_hlow.size() > 0) begin
                check("a_hsync_low_len", a_hlow, q_a_hlow.pop_front());
            end
        end
        if (b_reset) begin
            b_vlow    = -1;
            b_fs_last = -1;
            b_lvid    = 0;
        end else if (cyc >= 3) begin
            if (b_x == 10'd0 && pb_x == 10'd799) begin
                if (q_b_lvid.size() > 0) check("b_line_video", b_lvid, q_b_lvid.pop_front());
                b_lvid = 0;
            end
            if (b_vid === 1'b1) begin
                b_lvid++;
                if (q_b_vid.size() > 0)
                    check("b_video_act_x", int'(b_act) * 1000 + int'(b_x), q_b_vid.pop_front());
            end
            if (b_vs === 1'b0) begin
                if (pb_vs === 1'b1) begin
                    if (q_b_vfall.size() > 0)
                        check("b_vfall_yx", int'(b_y) * 1000 + int'(b_x), q_b_vfall.pop_front());
                    b_vlow = 0;
                end
                if (b_vlow >= 0) b_vlow++;
            end else if (pb_vs === 1'b0 && b_vlow >= 0) begin
                if (q_b_vlow.size() > 0) check("b_vsync_low_len", b_vlow, q_b_vlow.pop_front());
                b_vlow = -1;
            end
            if (b_fs === 1'b1 && pb_fs === 1'b0) begin
                if (b_fs_last >= 0 && q_b_fsgap.size() > 0)
                    check("b_frame_gap", cyc - b_fs_last, q_b_fsgap.pop_front());
                b_fs_last = cyc;
            end
        end
        pa_x  = a_x;
        pa_hs = a_hs;
        pb_x  = b_x;
        pb_vs = b_vs;
        pb_fs = b_fs;
    end

    initial begin
        int c;
        a_reset = 1'b1;
        b_reset = 1'b1;
        a_pixel = 1'b1;

        // Reset held over posedges 1..3; cycle 3 is the first one with reset low.
        for (int k = 1; k <= 3; k++) begin
            push_snap(k, 0, 0, "a_rst_x");
            push_snap(k, 1, 0, "a_rst_y");
            push_snap(k, 2, 1, "a_rst_hs");
            push_snap(k, 3, 1, "a_rst_vs");
            push_snap(k, 4, 0, "a_rst_act");
            push_snap(k, 5, 0, "a_rst_vid");
        end
        push_snap(3, 6, 1, "a_fs_after_rst");
        push_snap(3, 13, 1, "b_rst_vs");
        push_snap(4, 0, 1, "a_x_first_step");
        push_snap(4, 4, 1, "a_act_lat1");
        push_snap(4, 5, 1, "a_vid_lat1");
        push_snap(4, 6, 0, "a_fs_one_wide");
        push_snap(5, 14, 0, "b_act_lat3_early");
        push_snap(6, 14, 1, "b_act_lat3");
        push_snap(659, 2, 1, "a_hs_before_fall");
        push_snap(660, 2, 0, "a_hs_fall");
        push_snap(660, 3, 1, "a_vs_idle");
        push_snap(755, 2, 0, "a_hs_last_low");
        push_snap(756, 2, 1, "a_hs_rise");
        push_snap(802, 0, 799, "a_x_last");
        push_snap(802, 1, 0, "a_y_before_wrap");
        push_snap(803, 0, 0, "a_x_wrap");
        push_snap(803, 1, 1, "a_y_step");
        push_snap(8002, 10, 799, "b_x_last");
        push_snap(8002, 11, 9, "b_y_last");
        push_snap(8002, 16, 0, "b_fs_before");
        push_snap(8003, 11, 0, "b_y_wrap");
        push_snap(8003, 16, 1, "b_fs_pulse");
        push_snap(8004, 16, 0, "b_fs_after");

        repeat (4) q_a_hfx.push_back(656);
        repeat (3) q_a_hgap.push_back(800);
        repeat (4) q_a_hlow.push_back(96);
        repeat (4) q_a_lvid.push_back(640);
        repeat (2) q_a_lvid.push_back(0);
        repeat (3) q_b_vfall.push_back(6003);
        repeat (2) q_b_vlow.push_back(1600);
        repeat (8) q_b_vid.push_back(1008);
        repeat (2) begin
            repeat (4) q_b_lvid.push_back(1);
            repeat (6) q_b_lvid.push_back(0);
        end
        q_b_fsgap.push_back(8000);

        repeat (3) @(posedge clk);
        #1;
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Drop A's pixel at the start of line 4; lines 4 and 5 must show no video.
        do begin
            @(posedge clk);
            #1;
        end while (!(a_x == 10'd0 && a_y == 10'd4) && cyc < 8000);
        if (a_x == 10'd0 && a_y == 10'd4) a_pixel = 1'b0;
        else check("a_line4_timeout", 0, 1);

        // Hit B with reset in the middle of both sync pulses of its third frame.
        do begin
            @(posedge clk);
            #1;
        end while (!(cyc > 16100 && b_x == 10'd700 && b_y == 10'd7) && cyc < 30000);
        if (b_x == 10'd700 && b_y == 10'd7) begin
            c = cyc;
            push_snap(c, 12, 0, "b_hs_low_pre_rst");
            push_snap(c, 13, 0, "b_vs_low_pre_rst");
            push_snap(c + 1, 12, 1, "b_hs_on_rst");
            push_snap(c + 1, 13, 1, "b_vs_on_rst");
            push_snap(c + 1, 10, 0, "b_x_on_rst");
            push_snap(c + 1, 11, 0, "b_y_on_rst");
            push_snap(c + 1, 14, 0, "b_act_on_rst");
            push_snap(c + 2, 10, 0, "b_x_restart");
            push_snap(c + 2, 16, 1, "b_fs_restart");
            push_snap(c + 3, 10, 1, "b_x_after_restart");
            push_snap(c + 3, 16, 0, "b_fs_after_restart");
            push_snap(c + 5, 12, 1, "b_hs_no_partial");
            push_snap(c + 5, 13, 1, "b_vs_no_partial");
            push_snap(c + 802, 10, 0, "b_x_line1");
            push_snap(c + 802, 11, 1, "b_y_line1");
            b_reset = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            b_reset = 1'b0;
        end else begin
            check("b_midsync_timeout", 0, 1);
        end

        repeat (1000) @(posedge clk);
        #1;

        foreach (snap_q[i]) check({snap_q[i].name, "_missing"}, -1, snap_q[i].exp);
        foreach (q_a_hfx[i]) check("a_hfall_missing", -1, q_a_hfx[i]);
        foreach (q_a_hgap[i]) check("a_hgap_missing", -1, q_a_hgap[i]);
        foreach (q_a_hlow[i]) check("a_hlow_missing", -1, q_a_hlow[i]);
        foreach (q_a_lvid[i]) check("a_lvid_missing", -1, q_a_lvid[i]);
        foreach (q_b_vfall[i]) check("b_vfall_missing", -1, q_b_vfall[i]);
        foreach (q_b_vlow[i]) check("b_vlow_missing", -1, q_b_vlow[i]);
        foreach (q_b_vid[i]) check("b_vid_missing", -1, q_b_vid[i]);
        foreach (q_b_lvid[i]) check("b_lvid_missing", -1, q_b_lvid[i]);
        foreach (q_b_fsgap[i]) check("b_fsgap_missing", -1, q_b_fsgap[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mod_vga_timing.md
Name: mod_vga_timing

Overview:
- Source end of the pixel-position interface: generates 640x480@60 VGA raster counters (out_pix_x/out_pix_y) that overlay modules such as the hex display consume.
- Takes back their 1-bit pixel result and drives active-low syncs plus a gated video bit.
- A configurable delay line aligns syncs and blanking with the overlay's pixel latency, closing the one-cycle misalignment currently carried by overlays.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_LATENCY, 1, cycles from out_pix_x/y to the matching in_pixel; legal range 1..4

Ports:
- in_clk  input  1  pixel clock (25.175 MHz nominal); single clock domain
- in_reset  input  1  synchronous, active-high reset
- in_pixel  input  1  overlay pixel result, valid PIX_LATENCY cycles after its coordinates
- out_pix_x  output  10  horizontal counter, 0..H_TOTAL-1
- out_pix_y  output  10  vertical counter, 0..V_TOTAL-1
- out_frame_start  output  1  high exactly while out_pix_x==0 and out_pix_y==0
- out_active  output  1  delayed visible-region flag, aligned with in_pixel
- out_hsync  output  1  active-low hsync, aligned with in_pixel
- out_vsync  output  1  active-low vsync, aligned with in_pixel
- out_video  output  1  in_pixel AND out_active

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
  - Both must be <= 1024; 10-bit counters.
- Counters:
  - out_pix_x and out_pix_y are registered counter values.
  - x increments every cycle; at H_TOTAL-1 it wraps to 0 and y increments.
  - When x wraps and y==V_TOTAL-1, y also wraps to 0 in the same cycle.
- Decode (combinational from counters):
  - act = (x<H_ACTIVE) && (y<V_ACTIVE)
  - hs_n = 0 when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751), else 1
  - vs_n = 0 when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491), else 1
  - vsync changes state only at x==0 boundaries.
- Delay line:
  - act, hs_n and vs_n pass through exactly PIX_LATENCY register stages to give out_active, out_hsync and out_vsync.
  - An output at cycle t reflects the counter value at cycle t-PIX_LATENCY.
- out_video is a combinational AND of in_pixel and the registered out_active; it is never high outside the visible region.
- out_frame_start is decoded from the registered counters, undelayed, one cycle wide per frame.
- Reset (synchronous; wins over counting on the same edge):
  - x=0, y=0.
  - Every delay-line stage loads idle: act=0, hs_n=1, vs_n=1.
  - Hence after reset: out_active=0, out_hsync=1, out_vsync=1, out_video=0.
  - out_frame_start=1 in the first cycle after reset, since the counters are at 0,0.
- Reset mid-frame:
  - Aborts the frame immediately; no partial sync pulse may be emitted after reset asserts.
  - The raster restarts at (0,0) on the first cycle with in_reset low.
- No other inputs; the block free-runs whenever reset is low.

Test Plan:
- Reset values: hold in_reset 3 cycles, then release -> during reset and the cycle after, out_hsync=1, out_vsync=1, out_active=0, out_video=0, out_pix_x=0, out_pix_y=0; out_frame_start=1 the cycle after release.
- Line timing (PIX_LATENCY=1):
  - out_pix_x sequence 0..799 then 0; out_pix_y increments on that wrap.
  - out_hsync low for exactly 96 cycles, falling one cycle after out_pix_x==656.
  - Successive hsync falling edges are 800 cycles apart.
- Frame timing:
  - out_vsync low for exactly 1600 cycles, starting one cycle after (x=0,y=490).
  - out_frame_start pulses every 420000 cycles; y wraps from 524 to 0.
- Video gating: in_pixel held 1 -> out_video high for 640 consecutive cycles per line on 480 lines per frame, 0 elsewhere; in_pixel held 0 -> out_video always 0.
- Latency alignment: PIX_LATENCY=3, with in_pixel driven as a 3-cycle-delayed copy of (out_pix_x==5) -> out_video high on exactly one cycle per visible line, coincident with out_active high and 3 cycles after out_pix_x==5.
- Reset mid-sync: assert in_reset at out_pix_x==700, out_pix_y==491 (both syncs low) -> out_hsync and out_vsync both 1 on the edge after the reset edge, and counters restart at (0,0) once in_reset drops.
